sobel_window_ctrl: RTL and testbench
====================================

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 5: pixels per line, minimum 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 4: lines per frame, minimum 3.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port pix_valid_i, input, 1: one pixel presented this cycle.
REQ-006 SHALL have port sof_i, input, 1: start of frame; qualifies the first pixel of a frame together with pix_valid_i.
REQ-007 SHALL have port lb0_we_o, output, 1: write enable for the first line buffer stage.
REQ-008 SHALL have port lb1_we_o, output, 1: write enable for the second line buffer stage.
REQ-009 SHALL have port col_o, output, clog2(IMG_WIDTH): column of the last accepted pixel.
REQ-010 SHALL have port row_o, output, clog2(IMG_HEIGHT): row of the last accepted pixel.
REQ-011 SHALL have port win_valid_o, output, 1: 3x3 window is complete and valid for the Sobel kernel.
REQ-012 SHALL have port line_done_o, output, 1: single-cycle end-of-line pulse.
REQ-013 SHALL have port frame_done_o, output, 1: single-cycle end-of-frame pulse.
REQ-014 SHALL have port err_o, output, 1: sticky protocol error; present only under SOBEL_CTRL_ERR_EN.

Function
REQ-015 SHALL implement the FSM states IDLE, FILL, RUN and DONE.
REQ-016 Pixel accept SHALL be defined as: in IDLE, pix_valid_i AND sof_i; in FILL or RUN, pix_valid_i; in DONE, never.
REQ-017 lb0_we_o SHALL equal accept, combinationally, with zero latency, so the line buffer writes in the same cycle.
REQ-018 lb1_we_o SHALL equal accept AND (current row >= 1), combinationally.
REQ-019 col SHALL advance 0..IMG_WIDTH-1 on each accept, then wrap to 0; row SHALL increment on col wrap; col_o/row_o SHALL be registered.
REQ-020 FSM transitions SHALL be: IDLE->FILL on accept; FILL->RUN on accepting col=W-1 of row 1; RUN->DONE on accepting col=W-1, row=H-1; DONE->IDLE after one cycle unconditionally.
REQ-021 win_valid_o SHALL assert, registered with latency 1, for each accepted pixel with row>=2 and col>=2; this gives exactly (W-2)*(H-2) pulses per frame.
REQ-022 line_done_o SHALL pulse one cycle after accepting col=W-1.
REQ-023 frame_done_o SHALL assert exactly during DONE.
REQ-024 When pix_valid_i is low, the block SHALL hold counters and state, and all pulse outputs SHALL be 0.
REQ-025 sof_i with pix_valid_i in FILL or RUN SHALL restart the frame: the pixel is accepted as col 0, row 0, and the state goes to FILL; no frame_done_o is issued.
REQ-026 sof_i without pix_valid_i SHALL be ignored.
REQ-027 pix_valid_i in IDLE without sof_i SHALL be dropped, with no write enables and no counter change.

Reset
REQ-028 When rst is high, the next edge SHALL give: state IDLE, col_o=0, row_o=0, win_valid_o=0, line_done_o=0, frame_done_o=0, err_o=0.
REQ-029 rst SHALL take priority over every input, including mid-frame; lb0_we_o and lb1_we_o SHALL be 0 while rst is high.

Configuration
REQ-030 With SOBEL_CTRL_ERR_EN defined, err_o SHALL set on the edge after a frame restart per REQ-025, and SHALL clear only on rst.
REQ-031 Without SOBEL_CTRL_ERR_EN, the port err_o and its logic SHALL be absent, and REQ-025 behaviour SHALL be unchanged.

Structure
REQ-032 Package sobel_pkg SHALL hold the FSM state typedef and encodings, and the default IMG_WIDTH/IMG_HEIGHT constants.
REQ-033 There SHALL be one sub-module, sobel_pix_counter (col/row counter with wrap and terminal flags), instantiated once.

Verification
REQ-034 Use W=5, H=4, sof_i with continuous pix_valid_i for 20 cycles: expect 20 lb0_we_o, 15 lb1_we_o, 6 win_valid_o, 4 line_done_o, 1 frame_done_o one cycle after the last accept.
REQ-035 Hold pix_valid_i low for 3 cycles mid-row 2: expect counters held, no pulses, then correct resume; the totals of REQ-034 are still met.
REQ-036 Assert sof_i with a pixel at row 2, col 3: expect col_o=0, row_o=0, state FILL, no frame_done_o, and err_o=1 under SOBEL_CTRL_ERR_EN.
REQ-037 Assert rst at row 3, col 1: expect all outputs 0 on the next edge; pixels without sof_i are dropped until the next sof_i.
REQ-038 Send pix_valid_i during DONE and during IDLE without sof_i: expect no write enables and no counter change.
REQ-039 Run two back-to-back frames: expect frame_done_o twice, win_valid_o 12 in total, and row_o wraps to 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel 3x3 window controller.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int IMG_WIDTH_DEF  = 5;
  localparam int IMG_HEIGHT_DEF = 4;

endpackage

// File: rtl/sobel_pix_counter.sv
// Column/row position counter for the Sobel window controller.
// cur_* is the position of the pixel presented this cycle; col_o/row_o hold the last accepted one.
module sobel_pix_counter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adv_i,
  input  logic                          sof_pix_i,
  output logic [$clog2(IMG_WIDTH)-1:0]  cur_col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] cur_row_o,
  output logic                          col_last_o,
  output logic                          row_last_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] nxt_col_q, nxt_col_d, col_q;
  logic [RW-1:0] nxt_row_q, nxt_row_d, row_q;

  // A start-of-frame pixel always lands at the origin, whatever the counter holds.
  assign cur_col_o  = sof_pix_i ? '0 : nxt_col_q;
  assign cur_row_o  = sof_pix_i ? '0 : nxt_row_q;
  assign col_last_o = (cur_col_o == CW'(IMG_WIDTH - 1));
  assign row_last_o = (cur_row_o == RW'(IMG_HEIGHT - 1));
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    if (adv_i) begin
      if (col_last_o) begin
        nxt_col_d = '0;
        nxt_row_d = row_last_o ? '0 : cur_row_o + RW'(1);
      end else begin
        nxt_col_d = cur_col_o + CW'(1);
        nxt_row_d = cur_row_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_col_q <= '0;
      nxt_row_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      nxt_col_q <= nxt_col_d;
      nxt_row_q <= nxt_row_d;
      if (adv_i) begin
        col_q <= cur_col_o;
        row_q <= cur_row_o;
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Control FSM for a 3x3 Sobel window: line-buffer write enables, window-valid and line/frame pulses.
// Define SOBEL_CTRL_ERR_EN to add the sticky err_o flag raised by a mid-frame restart.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid_i,
  input  logic                          sof_i,
  output logic                          lb0_we_o,
  output logic                          lb1_we_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic                          win_valid_o,
  output logic                          line_done_o,
  output logic                          frame_done_o
`ifdef SOBEL_CTRL_ERR_EN
  ,
  output logic                          err_o
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  state_e        state_q;
  logic          sof_pix, accept, restart;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          col_last, row_last;
  logic          win_valid_q, line_done_q, frame_done_q;

  assign sof_pix = pix_valid_i & sof_i;

  always_comb begin
    accept = 1'b0;
    case (state_q)
      ST_IDLE:         accept = sof_pix;
      ST_FILL, ST_RUN: accept = pix_valid_i;
      default:         accept = 1'b0;
    endcase
    if (rst) accept = 1'b0;
  end

  assign restart  = ~rst & sof_pix & ((state_q == ST_FILL) | (state_q == ST_RUN));
  assign lb0_we_o = accept;
  assign lb1_we_o = accept & (cur_row != '0);

  sobel_pix_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .adv_i     (accept),
    .sof_pix_i (sof_pix),
    .cur_col_o (cur_col),
    .cur_row_o (cur_row),
    .col_last_o(col_last),
    .row_last_o(row_last),
    .col_o     (col_o),
    .row_o     (row_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_valid_q  <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= accept & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
      line_done_q  <= accept & col_last;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_FILL;
        ST_FILL: begin
          if (restart) state_q <= ST_FILL;
          else if (accept && col_last && (cur_row == RW'(1))) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // A restart abandons the frame silently; only a completed frame reaches DONE.
          if (restart) begin
            state_q <= ST_FILL;
          end else if (accept && col_last && row_last) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign win_valid_o  = win_valid_q;
  assign line_done_o  = line_done_q;
  assign frame_done_o = frame_done_q;

`ifdef SOBEL_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (restart) err_q <= 1'b1;
  end
  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl against a pixel-index reference model.
module tb_sobel_window_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic clk = 1'b0;
  logic rst, pix_valid_i, sof_i;
  logic lb0, lb1, win, line, fd;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
`ifdef SOBEL_CTRL_ERR_EN
  logic err;
`endif

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid_i (pix_valid_i),
    .sof_i       (sof_i),
    .lb0_we_o    (lb0),
    .lb1_we_o    (lb1),
    .col_o       (col),
    .row_o       (row),
    .win_valid_o (win),
    .line_done_o (line),
    .frame_done_o(fd)
`ifdef SOBEL_CTRL_ERR_EN
    ,
    .err_o       (err)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  logic o_lb0, o_lb1, o_win, o_line, o_fd, o_err;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic e_lb0, e_lb1, e_win, e_line, e_fd, e_err;
  logic [CW-1:0] e_col;
  logic [RW-1:0] e_row;
  int c_lb0, c_lb1, c_win, c_line, c_fd;

  // Reference model: a frame is a linear run of W*H pixel indices.
  bit m_active, m_done, m_err;
  int m_idx, m_col, m_row;

  task automatic model(input bit v, input bit s, input bit r);
    bit acc;
    int c, rr;
    e_lb0 = 0; e_lb1 = 0; e_win = 0; e_line = 0; e_fd = 0;
    if (r) begin
      m_active = 0; m_done = 0; m_err = 0; m_idx = 0; m_col = 0; m_row = 0;
    end else begin
      acc    = v && !m_done && (m_active || s);
      m_done = 0;
      if (acc) begin
        if (s) begin
          if (m_active) m_err = 1;
          m_idx = 0;
          m_active = 1;
        end
        c  = m_idx % W;
        rr = m_idx / W;
        e_lb0  = 1;
        e_lb1  = (rr >= 1);
        e_win  = (rr >= 2) && (c >= 2);
        e_line = (c == W - 1);
        m_col  = c;
        m_row  = rr;
        m_idx++;
        if (m_idx == W * H) begin
          m_active = 0;
          m_done   = 1;
          e_fd     = 1;
        end
      end
    end
    e_col = CW'(m_col);
    e_row = RW'(m_row);
    e_err = m_err;
  endtask

  task automatic step(input bit v, input bit s, input bit r);
    @(negedge clk);
    pix_valid_i = v;
    sof_i       = s;
    rst         = r;
    #1;
    o_lb0 = lb0;
    o_lb1 = lb1;
    model(v, s, r);
    @(posedge clk);
    #1;
    o_win  = win;
    o_line = line;
    o_fd   = fd;
    o_col  = col;
    o_row  = row;
`ifdef SOBEL_CTRL_ERR_EN
    o_err = err;
`else
    o_err = 1'b0;
`endif
    c_lb0  += int'(o_lb0);
    c_lb1  += int'(o_lb1);
    c_win  += int'(o_win);
    c_line += int'(o_line);
    c_fd   += int'(o_fd);
  endtask

  task automatic clear_counts();
    c_lb0 = 0; c_lb1 = 0; c_win = 0; c_line = 0; c_fd = 0;
  endtask

  task automatic test_reset();
    step(1, 1, 1);
    n_checks++;
    if ({o_lb0, o_lb1} !== 2'b00) begin
      n_err++; $display("FAIL reset_we got=%b exp=00", {o_lb0, o_lb1});
    end
    n_checks++;
    if ({o_win, o_line, o_fd} !== 3'b000) begin
      n_err++; $display("FAIL reset_pulses got=%b exp=000", {o_win, o_line, o_fd});
    end
    n_checks++;
    if (o_col !== '0 || o_row !== '0) begin
      n_err++; $display("FAIL reset_pos got col=%0d row=%0d exp 0/0", o_col, o_row);
    end
`ifdef SOBEL_CTRL_ERR_EN
    n_checks++;
    if (o_err !== 1'b0) begin
      n_err++; $display("FAIL reset_err got=%b exp=0", o_err);
    end
`endif
    step(0, 0, 0);
  endtask

  task automatic test_full_frame();
    clear_counts();
    for (int i = 0; i < W * H; i++) begin
      step(1, i == 0, 0);
      n_checks++;
      if ({o_lb0, o_lb1, o_win, o_line, o_fd, o_col, o_row} !==
          {e_lb0, e_lb1, e_win, e_line, e_fd, e_col, e_row}) begin
        n_err++;
        $display("FAIL frame_cycle i=%0d got=%b exp=%b", i,
                 {o_lb0, o_lb1, o_win, o_line, o_fd, o_col, o_row},
                 {e_lb0, e_lb1, e_win, e_line, e_fd, e_col, e_row});
      end
    end
    step(0, 0, 0);
    n_checks++;
    if (o_fd !== 1'b0) begin
      n_err++; $display("FAIL frame_done_width got=%b exp=0", o_fd);
    end
    n_checks++;
    if ({c_lb0, c_lb1, c_win, c_line, c_fd} !== {32'd20, 32'd15, 32'd6, 32'd4, 32'd1}) begin
      n_err++;
      $display("FAIL frame_totals got lb0=%0d lb1=%0d win=%0d line=%0d fd=%0d exp 20/15/6/4/1",
               c_lb0, c_lb1, c_win, c_line, c_fd);
    end
  endtask

  task automatic test_stall();
    clear_counts();
    for (int i = 0; i < 12; i++) step(1, i == 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      n_checks++;
      if ({o_lb0, o_lb1, o_win, o_line, o_fd} !== 5'b0 || o_col !== CW'(1) || o_row !== RW'(2)) begin
        n_err++;
        $display("FAIL stall_hold k=%0d got pulses=%b col=%0d row=%0d exp 0/1/2", k,
                 {o_lb0, o_lb1, o_win, o_line, o_fd}, o_col, o_row);
      end
    end
    step(1, 0, 0);
    n_checks++;
    if (o_col !== CW'(2) || o_row !== RW'(2) || o_win !== 1'b1) begin
      n_err++;
      $display("FAIL stall_resume got col=%0d row=%0d win=%b exp 2/2/1", o_col, o_row, o_win);
    end
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    step(0, 0, 0);
    n_checks++;
    if ({c_lb0, c_lb1, c_win, c_line, c_fd} !== {32'd20, 32'd15, 32'd6, 32'd4, 32'd1}) begin
      n_err++;
      $display("FAIL stall_totals got lb0=%0d lb1=%0d win=%0d line=%0d fd=%0d exp 20/15/6/4/1",
               c_lb0, c_lb1, c_win, c_line, c_fd);
    end
  endtask

  task automatic test_restart();
    clear_counts();
    for (int i = 0; i < 13; i++) step(1, i == 0, 0);
    step(1, 1, 0);
    n_checks++;
    if (o_lb0 !== 1'b1 || o_col !== '0 || o_row !== '0 || o_fd !== 1'b0) begin
      n_err++;
      $display("FAIL restart_pos got we=%b col=%0d row=%0d fd=%b exp 1/0/0/0", o_lb0, o_col, o_row, o_fd);
    end
`ifdef SOBEL_CTRL_ERR_EN
    n_checks++;
    if (o_err !== 1'b1) begin
      n_err++; $display("FAIL restart_err got=%b exp=1", o_err);
    end
`endif
    for (int i = 0; i < W * H - 1; i++) step(1, 0, 0);
    n_checks++;
    if (o_fd !== 1'b1 || c_fd !== 1 || c_win !== 7) begin
      n_err++;
      $display("FAIL restart_frame got fd=%b fd_count=%0d win=%0d exp 1/1/7", o_fd, c_fd, c_win);
    end
`ifdef SOBEL_CTRL_ERR_EN
    n_checks++;
    if (o_err !== 1'b1) begin
      n_err++; $display("FAIL restart_err_sticky got=%b exp=1", o_err);
    end
`endif
    step(0, 0, 0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 16; i++) step(1, i == 0, 0);
    step(1, 0, 1);
    n_checks++;
    if ({o_lb0, o_lb1, o_win, o_line, o_fd} !== 5'b0 || o_col !== '0 || o_row !== '0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got pulses=%b col=%0d row=%0d err=%b exp all 0",
               {o_lb0, o_lb1, o_win, o_line, o_fd}, o_col, o_row, o_err);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      n_checks++;
      if ({o_lb0, o_lb1, o_win, o_line, o_fd} !== 5'b0 || o_col !== '0 || o_row !== '0) begin
        n_err++;
        $display("FAIL rst_drop k=%0d got pulses=%b col=%0d row=%0d exp 0",
                 k, {o_lb0, o_lb1, o_win, o_line, o_fd}, o_col, o_row);
      end
    end
    step(1, 1, 0);
    n_checks++;
    if (o_lb0 !== 1'b1 || o_col !== '0 || o_row !== '0) begin
      n_err++; $display("FAIL rst_resume got we=%b col=%0d row=%0d exp 1/0/0", o_lb0, o_col, o_row);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < W * H - 1; i++) step(1, 0, 0);
    n_checks++;
    if (o_fd !== 1'b1 || o_col !== CW'(W - 1) || o_row !== RW'(H - 1)) begin
      n_err++; $display("FAIL drop_end got fd=%b col=%0d row=%0d exp 1/4/3", o_fd, o_col, o_row);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      n_checks++;
      if ({o_lb0, o_lb1, o_fd} !== 3'b000 || o_col !== CW'(W - 1) || o_row !== RW'(H - 1)) begin
        n_err++;
        $display("FAIL drop_k%0d got we=%b fd=%b col=%0d row=%0d exp 0/0/4/3",
                 k, {o_lb0, o_lb1}, o_fd, o_col, o_row);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        step(1, i == 0, 0);
        if (f == 1 && i == 0) begin
          n_checks++;
          if (o_row !== '0 || o_col !== '0) begin
            n_err++; $display("FAIL b2b_wrap got col=%0d row=%0d exp 0/0", o_col, o_row);
          end
        end
      end
      step(0, 0, 0);
    end
    n_checks++;
    if (c_fd !== 2 || c_win !== 12 || c_lb0 !== 40) begin
      n_err++; $display("FAIL b2b_totals got fd=%0d win=%0d lb0=%0d exp 2/12/40", c_fd, c_win, c_lb0);
    end
  endtask

  task automatic test_random();
    bit v, s, r;
    step(0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 99) < 80);
      s = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) < 1);
      step(v, s, r);
      n_checks++;
      if ({o_lb0, o_lb1, o_win, o_line, o_fd, o_col, o_row} !==
          {e_lb0, e_lb1, e_win, e_line, e_fd, e_col, e_row}) begin
        n_err++;
        $display("FAIL rand_cycle i=%0d v=%b s=%b r=%b got=%b exp=%b", i, v, s, r,
                 {o_lb0, o_lb1, o_win, o_line, o_fd, o_col, o_row},
                 {e_lb0, e_lb1, e_win, e_line, e_fd, e_col, e_row});
      end
`ifdef SOBEL_CTRL_ERR_EN
      n_checks++;
      if (o_err !== e_err) begin
        n_err++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, o_err, e_err);
      end
`endif
    end
  endtask

  initial begin
    rst         = 1'b1;
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    clear_counts();
    test_reset();
    test_full_frame();
    test_stall();
    test_restart();
    test_rst_mid();
    test_drop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
